// File: rtl/throw_turn_ctl.sv
// Turn/launch sequencer: force-meter charge on mouse button, timed throw enable, hit scoring, game over.
// Build option AUTO_DOG_EN: the dog throws on its own with an LFSR-derived force.
module throw_turn_ctl #(
   parameter int unsigned TICK_DIV     = 1300000,
   parameter int unsigned FORCE_STEP   = 16,
   parameter int unsigned FLIGHT_TICKS = 60,
   parameter int unsigned MAX_HP       = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_i,
   input  logic       hit_cat_i,
   input  logic       hit_dog_i,
   output logic [9:0] throw_force_o,
   output logic       enable_cat_o,
   output logic       enable_dog_o,
   output logic       turn_o,
   output logic [2:0] cat_hp_o,
   output logic [2:0] dog_hp_o,
   output logic       charging_o,
   output logic       game_over_o,
   output logic       winner_o
);

   // state   | meaning
   // IDLE    | waiting for a fresh press (or auto dog tick)
   // CHARGE  | button held, meter ping-pongs each tick
   // FLIGHT  | active player's enable high for FLIGHT_TICKS ticks
   // RESOLVE | apply hit to opponent, pick next turn or end
   // OVER    | game finished, press restarts
   typedef enum logic [2:0] {
      S_IDLE, S_CHARGE, S_FLIGHT, S_RESOLVE, S_OVER
   } state_e;

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FLT_W  = $clog2(FLIGHT_TICKS + 1);
   localparam logic [2:0]  HP_INIT = 3'(MAX_HP);
   localparam logic [10:0] STEP    = 11'(FORCE_STEP);

   state_e             state_q, state_d;
   logic [9:0]         meter_q, meter_d;
   logic               dir_q, dir_d;
   logic [9:0]         force_q, force_d;
   logic               turn_q, turn_d;
   logic [2:0]         cat_hp_q, cat_hp_d;
   logic [2:0]         dog_hp_q, dog_hp_d;
   logic               winner_q, winner_d;
   logic               hit_q, hit_d;
   logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
   logic [TICK_W-1:0]  tick_cnt_q;
   logic               btn_s1_q, btn_s2_q, btn_s3_q;
   logic               tick, press, release_ev, hit_acc;
   logic [2:0]         opp_hp, opp_hp_dec;
   logic [10:0]        meter_up;

   assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign press      = btn_s2_q & ~btn_s3_q;
   assign release_ev = ~btn_s2_q & btn_s3_q;
   assign hit_acc    = turn_q ? hit_dog_i : hit_cat_i;
   assign opp_hp     = turn_q ? cat_hp_q : dog_hp_q;
   assign opp_hp_dec = (hit_q && opp_hp != 3'd0) ? opp_hp - 3'd1 : opp_hp;
   assign meter_up   = {1'b0, meter_q} + STEP;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt_q <= '0;
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         btn_s3_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
         btn_s1_q   <= btn_i;
         btn_s2_q   <= btn_s1_q;
         btn_s3_q   <= btn_s2_q;
      end
   end

`ifdef AUTO_DOG_EN
   logic [9:0] lfsr_q;

   // x^10 + x^7 + 1, maximal length
   always_ff @(posedge clk_i) begin
      if (rst_i) lfsr_q <= 10'h2A5;
      else       lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         meter_q   <= '0;
         dir_q     <= 1'b0;
         force_q   <= '0;
         turn_q    <= 1'b0;
         cat_hp_q  <= HP_INIT;
         dog_hp_q  <= HP_INIT;
         winner_q  <= 1'b0;
         hit_q     <= 1'b0;
         flt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         meter_q   <= meter_d;
         dir_q     <= dir_d;
         force_q   <= force_d;
         turn_q    <= turn_d;
         cat_hp_q  <= cat_hp_d;
         dog_hp_q  <= dog_hp_d;
         winner_q  <= winner_d;
         hit_q     <= hit_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      meter_d   = meter_q;
      dir_d     = dir_q;
      force_d   = force_q;
      turn_d    = turn_q;
      cat_hp_d  = cat_hp_q;
      dog_hp_d  = dog_hp_q;
      winner_d  = winner_q;
      hit_d     = hit_q;
      flt_cnt_d = flt_cnt_q;
      case (state_q)
         S_IDLE: begin
`ifdef AUTO_DOG_EN
            if (turn_q) begin
               if (tick) begin
                  force_d   = lfsr_q;
                  flt_cnt_d = '0;
                  state_d   = S_FLIGHT;
               end
            end else
`endif
            if (press) begin
               meter_d = '0;
               dir_d   = 1'b0;
               state_d = S_CHARGE;
            end
         end
         S_CHARGE: begin
            // release wins over a same-cycle tick so the force is the value the player saw
            if (release_ev) begin
               force_d   = meter_q;
               flt_cnt_d = '0;
               state_d   = S_FLIGHT;
            end else if (tick) begin
               if (!dir_q) begin
                  if (meter_up > 11'd1023) begin
                     meter_d = 10'd1023;
                     dir_d   = 1'b1;
                  end else begin
                     meter_d = meter_up[9:0];
                  end
               end else begin
                  if ({1'b0, meter_q} < STEP) begin
                     meter_d = '0;
                     dir_d   = 1'b0;
                  end else begin
                     meter_d = meter_q - STEP[9:0];
                  end
               end
            end
         end
         S_FLIGHT: begin
            if (hit_acc) hit_d = 1'b1;
            if (tick) begin
               if (flt_cnt_q == FLT_W'(FLIGHT_TICKS - 1)) state_d = S_RESOLVE;
               else flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
         end
         S_RESOLVE: begin
            if (turn_q) cat_hp_d = opp_hp_dec;
            else        dog_hp_d = opp_hp_dec;
            hit_d = 1'b0;
            if (opp_hp_dec == 3'd0) begin
               winner_d = turn_q;
               state_d  = S_OVER;
            end else begin
               turn_d  = ~turn_q;
               state_d = S_IDLE;
            end
         end
         S_OVER: begin
            if (press) begin
               cat_hp_d = HP_INIT;
               dog_hp_d = HP_INIT;
               turn_d   = 1'b0;
               winner_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign throw_force_o = force_q;
   assign enable_cat_o  = (state_q == S_FLIGHT) && !turn_q;
   assign enable_dog_o  = (state_q == S_FLIGHT) && turn_q;
   assign turn_o        = turn_q;
   assign cat_hp_o      = cat_hp_q;
   assign dog_hp_o      = dog_hp_q;
   assign charging_o    = (state_q == S_CHARGE);
   assign game_over_o   = (state_q == S_OVER);
   assign winner_o      = winner_q;

endmodule

// File: tb/tb_throw_turn_ctl.sv
// Bench for throw_turn_ctl: directed throw table, corner sequences, and random play against a rule-level model.
module tb_throw_turn_ctl;
   localparam int TICK_DIV = 4;
   localparam int STEP     = 16;
   localparam int FLIGHT   = 60;
   localparam int MAX_HP   = 5;

   logic       clk = 1'b0, rst = 1'b1, btn = 1'b0, hit_cat = 1'b0, hit_dog = 1'b0;
   logic [9:0] throw_force;
   logic       enable_cat, enable_dog, turn, charging, game_over, winner;
   logic [2:0] cat_hp, dog_hp;

   throw_turn_ctl #(.TICK_DIV(TICK_DIV), .FORCE_STEP(STEP), .FLIGHT_TICKS(FLIGHT), .MAX_HP(MAX_HP)) u_dut (
      .clk_i(clk), .rst_i(rst), .btn_i(btn), .hit_cat_i(hit_cat), .hit_dog_i(hit_dog),
      .throw_force_o(throw_force), .enable_cat_o(enable_cat), .enable_dog_o(enable_dog),
      .turn_o(turn), .cat_hp_o(cat_hp), .dog_hp_o(dog_hp), .charging_o(charging),
      .game_over_o(game_over), .winner_o(winner));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Rule-level model. mode: 0 idle, 1 charging, 2 in flight, 3 resolving, 4 game over.
   int       m_mode, m_cnt, m_nch, m_nfl, m_cat, m_dog, m_force;
   bit       m_turn, m_win, m_hit, m_tick, m_press, m_rel, m_acc;
   bit [2:0] m_sync;
   bit [9:0] m_lfsr;

   // meter value after n ticks of charging, from the ping-pong rule
   function automatic int meter_after(int n);
      int m = 0;
      bit dn = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (!dn) begin
            if (m + STEP > 1023) begin m = 1023; dn = 1'b1; end
            else m = m + STEP;
         end else begin
            if (m < STEP) begin m = 0; dn = 1'b0; end
            else m = m - STEP;
         end
      end
      return m;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_nch = 0; m_nfl = 0; m_cat = MAX_HP; m_dog = MAX_HP;
         m_force = 0; m_turn = 0; m_win = 0; m_hit = 0; m_sync = 3'b000; m_lfsr = 10'h2A5;
      end else begin
         m_tick  = (m_cnt == TICK_DIV - 1);
         m_press = m_sync[1] && !m_sync[2];
         m_rel   = !m_sync[1] && m_sync[2];
         m_acc   = m_turn ? hit_dog : hit_cat;
         case (m_mode)
            0: begin
`ifdef AUTO_DOG_EN
               if (m_turn) begin
                  if (m_tick) begin m_force = int'(m_lfsr); m_nfl = 0; m_mode = 2; end
               end else
`endif
               if (m_press) begin m_nch = 0; m_mode = 1; end
            end
            1: begin
               if (m_rel) begin m_force = meter_after(m_nch); m_nfl = 0; m_mode = 2; end
               else if (m_tick) m_nch++;
            end
            2: begin
               if (m_acc) m_hit = 1'b1;
               if (m_tick) begin
                  m_nfl++;
                  if (m_nfl == FLIGHT) m_mode = 3;
               end
            end
            3: begin
               if (m_hit) begin
                  if (m_turn) m_cat = (m_cat > 0) ? m_cat - 1 : 0;
                  else        m_dog = (m_dog > 0) ? m_dog - 1 : 0;
               end
               m_hit = 1'b0;
               if ((m_turn ? m_cat : m_dog) == 0) begin m_win = m_turn; m_mode = 4; end
               else begin m_turn = !m_turn; m_mode = 0; end
            end
            default: begin
               if (m_press) begin m_cat = MAX_HP; m_dog = MAX_HP; m_turn = 0; m_win = 0; m_mode = 0; end
            end
         endcase
         m_cnt  = (m_cnt + 1) % TICK_DIV;
         m_sync = {m_sync[1:0], btn};
         m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_force", throw_force, m_force);
         chk("mdl_en_cat", enable_cat, (m_mode == 2) && !m_turn);
         chk("mdl_en_dog", enable_dog, (m_mode == 2) && m_turn);
         chk("mdl_turn", turn, m_turn);
         chk("mdl_cat_hp", cat_hp, m_cat);
         chk("mdl_dog_hp", dog_hp, m_dog);
         chk("mdl_charging", charging, m_mode == 1);
         chk("mdl_game_over", game_over, m_mode == 4);
         chk("mdl_winner", winner, m_win);
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // start a press so that the release lands on a tick edge
   task automatic align();
      for (int i = 0; i < 2 * TICK_DIV; i++) begin
         step(1);
         if (m_cnt == 0) return;
      end
      chk("align_timeout", 0, 1);
   endtask

   task automatic do_throw(input int nt, input int nhc, input int nhd, input bit trn,
                           output int en_w, output int oth_w);
      bit seen = 1'b0;
      align();
      btn = 1'b1;
      step(4 * nt + 1);
      btn = 1'b0;
      en_w = 0; oth_w = 0;
      for (int c = 0; c < 400; c++) begin
         step(1);
         hit_cat = (c == 20 && nhc > 0) || (c == 50 && nhc > 1);
         hit_dog = (c == 35 && nhd > 0) || (c == 65 && nhd > 1);
         if (trn ? enable_dog : enable_cat) begin en_w++; seen = 1'b1; end
         else if (seen) break;
         if (trn ? enable_cat : enable_dog) oth_w++;
      end
      hit_cat = 1'b0; hit_dog = 1'b0;
      step(3);
   endtask

   typedef struct {
      int nt, nhc, nhd, force_v, cat, dog, trn, over, win;
   } vec_t;
   vec_t tbl[10];

   int en_w, oth_w, hold;
   bit prev_turn, seen_dog;

   initial begin
      tbl[0] = '{10,  0, 0, 160,  5, 5, 1, 0, 0};
      tbl[1] = '{70,  1, 1, 927,  4, 5, 0, 0, 0};
      tbl[2] = '{3,   2, 1, 48,   4, 4, 1, 0, 0};
      tbl[3] = '{64,  0, 2, 1023, 3, 4, 0, 0, 0};
      tbl[4] = '{128, 1, 0, 0,    3, 3, 1, 0, 0};
      tbl[5] = '{127, 0, 1, 15,   2, 3, 0, 0, 0};
      tbl[6] = '{1,   1, 0, 16,   2, 2, 1, 0, 0};
      tbl[7] = '{0,   0, 1, 0,    1, 2, 0, 0, 0};
      tbl[8] = '{65,  1, 0, 1007, 1, 1, 1, 0, 0};
      tbl[9] = '{5,   0, 1, 80,   0, 1, 1, 1, 1};

      rst = 1'b1;
      step(2);
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst_force", throw_force, 0);
      chk("rst_cat_hp", cat_hp, MAX_HP);
      chk("rst_dog_hp", dog_hp, MAX_HP);
      chk("rst_enables", {enable_cat, enable_dog}, 0);
      chk("rst_status", {turn, charging, game_over, winner}, 0);

`ifndef AUTO_DOG_EN
      prev_turn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_throw(tbl[i].nt, tbl[i].nhc, tbl[i].nhd, prev_turn, en_w, oth_w);
         chk($sformatf("v%0d_enable_width", i), en_w, FLIGHT * TICK_DIV);
         chk($sformatf("v%0d_other_enable", i), oth_w, 0);
         chk($sformatf("v%0d_force", i), throw_force, tbl[i].force_v);
         chk($sformatf("v%0d_cat_hp", i), cat_hp, tbl[i].cat);
         chk($sformatf("v%0d_dog_hp", i), dog_hp, tbl[i].dog);
         chk($sformatf("v%0d_turn", i), turn, tbl[i].trn);
         chk($sformatf("v%0d_game_over", i), game_over, tbl[i].over);
         chk($sformatf("v%0d_winner", i), winner, tbl[i].win);
         prev_turn = tbl[i].trn[0];
      end

      // press in game over restarts without charging, even while held
      btn = 1'b1;
      step(6);
      chk("over_press_game_over", game_over, 0);
      chk("over_press_hp", {cat_hp, dog_hp}, {3'(MAX_HP), 3'(MAX_HP)});
      chk("over_press_turn", turn, 0);
      chk("over_press_winner", winner, 0);
      chk("over_press_charging", charging, 0);
      btn = 1'b0;
      step(4);

      // reset in the middle of a dog flight
      do_throw(2, 1, 0, 1'b0, en_w, oth_w);
      chk("pre_rst_force", throw_force, 32);
      chk("pre_rst_dog_hp", dog_hp, MAX_HP - 1);
      align();
      btn = 1'b1;
      step(5);
      btn = 1'b0;
      step(20);
      chk("mid_flight_enable_dog", enable_dog, 1);
      rst = 1'b1;
      step(1);
      chk("rst_flight_enable_dog", enable_dog, 0);
      chk("rst_flight_turn", turn, 0);
      chk("rst_flight_dog_hp", dog_hp, MAX_HP);
      chk("rst_flight_force", throw_force, 0);
      rst = 1'b0;
      step(3);
`else
      do_throw(10, 0, 0, 1'b0, en_w, oth_w);
      chk("auto_cat_force", throw_force, 160);
      chk("auto_turn", turn, 1);
      seen_dog = 1'b0;
      for (int c = 0; c < 12 && !seen_dog; c++) begin
         step(1);
         seen_dog = enable_dog;
      end
      chk("auto_dog_enable", seen_dog, 1);
      chk("auto_dog_force_nonzero", throw_force != 10'd0, 1);
      step(300);
`endif

      // random play
      hold = 0;
      for (int i = 0; i < 20000; i++) begin
         step(1);
         if (hold == 0) begin
            btn  = !btn;
            hold = btn ? $urandom_range(600, 1) : $urandom_range(300, 1);
         end else begin
            hold--;
         end
         hit_cat = ($urandom_range(63, 0) == 0);
         hit_dog = ($urandom_range(63, 0) == 0);
         rst     = ($urandom_range(4999, 0) == 0);
      end
      rst = 1'b0; btn = 1'b0; hit_cat = 1'b0; hit_dog = 1'b0;
      step(4);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
